reg_op_sequencer: RTL and testbench



---
 rtl/reg_op_sequencer_if.sv | 19 +
 rtl/reg_op_sequencer.sv | 74 +++++++
 tb/tb_reg_op_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/reg_op_sequencer_if.sv
// reg_op_sequencer_if: reg_op_t package and the instruction/strobe bus between the sequencer and its neighbours
package reg_op_seq_pkg;
  typedef enum logic [1:0] {REG_OP_NONE = 2'd0, REG_OP_READ = 2'd1, REG_OP_WRITE = 2'd2} reg_op_t;
endpackage

interface reg_op_sequencer_if #(parameter int NUM_REGS = 4, parameter int WIDTH = 8);
  logic instr_valid;
  logic instr_ready;
  logic [7:0] instr;
  reg_op_seq_pkg::reg_op_t [NUM_REGS-1:0] reg_op;
  logic [NUM_REGS-1:0] reg_save;
  logic [NUM_REGS-1:0] reg_restore;
  logic imm_oe;
  logic [WIDTH-1:0] imm_out;
  logic busy;
  logic err;
  modport master (output instr_valid, instr, input instr_ready, reg_op, reg_save, reg_restore, imm_oe, imm_out, busy, err);
  modport slave (input instr_valid, instr, output instr_ready, reg_op, reg_save, reg_restore, imm_oe, imm_out, busy, err);
endinterface

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: decodes instruction bytes into register-file strobes; REG_OP_SEQ_PIPELINE_EN allows one instruction per cycle
module reg_op_sequencer import reg_op_seq_pkg::*; #(
  parameter int NUM_REGS = 4,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  reg_op_sequencer_if.slave bus
);
`ifdef REG_OP_SEQ_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, EXEC, IMM_WAIT, IMM_EXEC} state_t;
  state_t state, state_n;
  logic [1:0] op_q;
  logic [2:0] dst_q, src_q;
  logic bad_q, err_q;
  logic [WIDTH-1:0] imm_q;
  logic ready, fire, take_op, bad, mov_ok, rd_ok;
  // accept gating, illegal-instruction decode and next state
  always_comb begin
    ready = PIPE || state == IDLE || state == IMM_WAIT;
    fire = bus.instr_valid && ready;
    take_op = fire && state != IMM_WAIT;
    bad = 32'(bus.instr[5:3]) >= NUM_REGS || (bus.instr[7:6] == 2'b00 &&
          (32'(bus.instr[2:0]) >= NUM_REGS || bus.instr[5:3] == bus.instr[2:0]));
    state_n = state == IMM_WAIT ? (fire ? IMM_EXEC : IMM_WAIT) :
              take_op ? (bus.instr[7:6] == 2'b11 ? IMM_WAIT : EXEC) : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // latched instruction fields, immediate and sticky error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= '0;
      dst_q <= '0;
      src_q <= '0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
      imm_q <= '0;
    end else begin
      if (take_op) begin
        op_q <= bus.instr[7:6];
        dst_q <= bus.instr[5:3];
        src_q <= bus.instr[2:0];
        bad_q <= bad;
      end
      if (fire && state == IMM_WAIT) imm_q <= WIDTH'(bus.instr);
      err_q <= err_q | (take_op && bad);
    end
  // strobes come only from registered state, so they change on posedge alone
  always_comb begin
    mov_ok = state == EXEC && !bad_q && op_q == 2'b00;
    rd_ok = mov_ok || (state == IMM_EXEC && !bad_q);
    bus.reg_op = {NUM_REGS{REG_OP_NONE}};
    bus.reg_save = '0;
    bus.reg_restore = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.reg_op[i] = (mov_ok && src_q == 3'(i)) ? REG_OP_WRITE :
                      (rd_ok && dst_q == 3'(i)) ? REG_OP_READ : REG_OP_NONE;
      bus.reg_save[i] = state == EXEC && !bad_q && op_q == 2'b01 && dst_q == 3'(i);
      bus.reg_restore[i] = state == EXEC && !bad_q && op_q == 2'b10 && dst_q == 3'(i);
    end
    bus.imm_oe = state == IMM_EXEC;
    bus.imm_out = state == IMM_EXEC ? imm_q : '0;
    bus.instr_ready = ready;
    bus.busy = state != IDLE;
    bus.err = err_q;
  end
endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer: scoreboard bench with an instruction-level reference model
module tb_reg_op_sequencer;
  import reg_op_seq_pkg::*;
  localparam int N = 4;
`ifdef REG_OP_SEQ_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  reg_op_sequencer_if #(.NUM_REGS(N), .WIDTH(8)) bus ();
  reg_op_sequencer #(.NUM_REGS(N), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int cyc;
    logic [N-1:0][1:0] op;
    logic [N-1:0] save;
    logic [N-1:0] restore;
    logic oe;
    logic [7:0] imm;
  } exp_t;
  exp_t q[$];
  int vectors = 0, fails = 0, cyc = 0;
  bit m_wait, m_bad, m_strobe, m_err, last_xfer;
  bit m_ready = 1'b1;
  int m_dst;
  int act_first = 0, act_last = 0, act_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endfunction
  task automatic model_reset();
    m_wait = 0; m_bad = 0; m_strobe = 0; m_err = 0; m_ready = 1; m_dst = 0;
    q.delete();
  endtask
  // instruction-level model: each accepted instruction yields one expected strobe cycle right after the edge
  task automatic model(input logic v, input logic [7:0] b);
    exp_t e;
    int op, d, s;
    bit bad, strobe;
    last_xfer = v && m_ready;
    strobe = 0;
    e.cyc = cyc + 1; e.op = '0; e.save = '0; e.restore = '0; e.oe = 0; e.imm = '0;
    if (last_xfer) begin
      op = int'(b[7:6]); d = int'(b[5:3]); s = int'(b[2:0]);
      if (m_wait) begin
        e.oe = 1; e.imm = b;
        if (!m_bad) e.op[m_dst] = REG_OP_READ;
        m_wait = 0; strobe = 1; q.push_back(e);
      end else begin
        bad = d >= N || (op == 0 && (s >= N || s == d));
        m_err |= bad;
        if (op == 3) begin
          m_wait = 1; m_dst = d; m_bad = bad;
        end else begin
          if (!bad && op == 0) begin e.op[s] = REG_OP_WRITE; e.op[d] = REG_OP_READ; end
          if (!bad && op == 1) e.save[d] = 1'b1;
          if (!bad && op == 2) e.restore[d] = 1'b1;
          strobe = 1; q.push_back(e);
        end
      end
    end
    m_strobe = strobe;
    m_ready = PIPE || !strobe;
  endtask
  task automatic drive(input logic v, input logic [7:0] b);
    bus.instr_valid = v;
    bus.instr = b;
    @(posedge clk);
    model(v, b);
    @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    do begin drive(1'b1, b); n++; end while (!last_xfer && n < 20);
    if (!last_xfer) chk("send_timeout", 0, 1);
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom));
  endtask
  // monitor: compares every out-of-reset cycle against the scoreboard head or the quiet vector
  initial begin
    exp_t e;
    logic [N-1:0][1:0] got_op;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e.cyc = cyc; e.op = '0; e.save = '0; e.restore = '0; e.oe = 0; e.imm = '0;
        if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
        got_op = bus.reg_op;
        chk("reg_op", got_op, e.op);
        chk("reg_save", bus.reg_save, e.save);
        chk("reg_restore", bus.reg_restore, e.restore);
        chk("imm_oe", bus.imm_oe, e.oe);
        chk("imm_out", bus.imm_out, e.imm);
        chk("err", bus.err, m_err);
        chk("instr_ready", bus.instr_ready, m_ready);
        chk("busy", bus.busy, m_strobe || m_wait);
        chk("save_restore_overlap", (|bus.reg_save) && (|bus.reg_restore), 0);
        chk("imm_write_overlap", bus.imm_oe && (got_op != '0) && ((got_op & {N{2'b10}}) != '0), 0);
        if (got_op != '0 || bus.reg_save != '0 || bus.reg_restore != '0 || bus.imm_oe) begin
          if (act_cnt == 0) act_first = cyc;
          act_last = cyc;
          act_cnt++;
        end
      end
    end
  end
  initial begin
    logic [7:0] b;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_reg_op", bus.reg_op, 0);
    chk("rst_imm_oe", bus.imm_oe, 0);
    chk("rst_err", bus.err, 0);
    #1 rst = 1'b0;
    #1 chk("rst_ready", bus.instr_ready, 1);
    send(8'h08); idle(2);
    send(8'hD0); idle(3); send(8'hA5); idle(2);
    send(8'h58); send(8'h98); idle(2);
    send(8'h09); idle(1); send(8'h38); idle(3);
    act_cnt = 0;
    send(8'h08); send(8'h11); send(8'h1A); send(8'h02); idle(3);
    chk("tput_count", act_cnt, 4);
    chk("tput_span", act_last - act_first, PIPE ? 3 : 6);
    send(8'hD8); idle(2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_reg_op", bus.reg_op, 0);
    chk("midrst_imm_oe", bus.imm_oe, 0);
    chk("midrst_err", bus.err, 0);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("midrst_ready", bus.instr_ready, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        b = 8'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          b[5:3] = 3'($urandom_range(0, N - 1));
          b[2:0] = 3'($urandom_range(0, N - 1));
        end
        drive(1'b1, b);
      end
    end
    idle(4);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
